noc_input_port: RTL and testbench
=================================

Name: noc_input_port

Overview:
- Input port of a 5-port mesh NoC router (Left, Right, Up, Down, local PE).
- Accepts 64-bit packets from an upstream link through a send/ready handshake and holds them in a small FIFO.
- Computes an XY route for the head packet and presents a request plus data toward exactly one output port.
- Pops the head packet when any output arbiter signals that it has consumed it.

Parameters:
- DATA_WIDTH, 64: packet width; field layout below assumes 64.
- CURRENT_ADDRESS, 16'h0000: this router's address; [15:8] = X, [7:0] = Y.
- DIRECTION, 5'b00001: one-hot code of this input port (00001 L, 00010 R, 00100 U, 01000 D, 10000 PE). Driven on req buses as the requester ID.
- BUFFER_DEPTH, 1: FIFO entries. Legal range 1..4.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- si, input, 1: upstream send strobe; datai is valid while si is high.
- buf_clear_1..buf_clear_4, input, 1 each: output-arbiter grant/consume strobes; any one pops the head entry.
- datai, input, DATA_WIDTH: incoming packet.
- ri, output, 1: ready-to-input; high when the FIFO is not full.
- reqL, reqR, reqU, reqD, reqPE, output, 5 each: per-output request; equals DIRECTION when routed there, else 0.
- dataoL, dataoR, dataoU, dataoD, dataoPE, output, DATA_WIDTH each: head packet on the routed output, else 0.

Behaviour:
- Packet fields:
  - [63] VC bit
  - [62:61] packet type
  - [60:56] reserved
  - [55:48] hop count
  - [47:32] destination address: [47:40] = X, [39:32] = Y
  - [31:0] payload
- Only the destination field affects routing. The packet is forwarded unmodified.
- Reset (rst=0, asynchronous):
  - FIFO empty; read/write pointers and count = 0.
  - ri=1.
  - All req* = 0 and all datao* = 0.
- Write: at a rising edge with si=1 and ri=1, datai is pushed. si while ri=0 is ignored and the data is dropped; upstream must honour ri.
- ri is combinational: ri = (count != BUFFER_DEPTH).
- Route is combinational from the head entry when count > 0, XY order:
  - dest X > cur X -> R
  - dest X < cur X -> L
  - else dest Y > cur Y -> U
  - else dest Y < cur Y -> D
  - else -> PE
- Outputs:
  - Exactly one req* = DIRECTION and the matching datao* = head packet. All other req*/datao* = 0.
  - Empty FIFO: all req*/datao* = 0.
  - Latency: a packet written at edge N is visible on req/datao after edge N, with ri updated in the same cycle.
- Pop: at a rising edge with count > 0 and any buf_clear_k = 1, the head is removed.
  - Multiple buf_clear in the same cycle cause a single pop.
  - buf_clear while empty is ignored.
- Simultaneous push and pop:
  - Both occur and count is unchanged.
  - With depth 1 and a full FIFO, ri=0 so no push occurs; the pop frees the slot and ri=1 next cycle.
- Pointers wrap modulo BUFFER_DEPTH and the FIFO preserves order.
- A U-turn (route equal to DIRECTION) is not blocked; the request is issued normally.
- Asserting reset mid-operation discards all buffered packets immediately.

Test Plan:
- Reset: rst=0 -> ri=1, all req*=0, all datao*=0. Release rst=1 -> outputs unchanged.
- Local delivery: datai=0xD000_0000_1111_1111 (dest 0x0000 = CURRENT_ADDRESS), si=1 for one edge.
  - Next cycle: ri=0, reqPE=5'b00001, dataoPE=0xD000_0000_1111_1111.
  - All other req*=0 and datao*=0.
- Clear: with that packet held, buf_clear_1=1 for one edge -> ri=1, reqPE=0, dataoPE=0. A repeated buf_clear_1 while empty changes nothing.
- Full drop: depth 1 full, second si with datai=...2222_2222 -> ignored. The head packet is still 0x...1111_1111.
- Routing: with CURRENT_ADDRESS=16'h0101:
  - dest 0x0201 -> reqR
  - dest 0x0001 -> reqL
  - dest 0x0102 -> reqU
  - dest 0x0100 -> reqD
  - In each case req value = DIRECTION.
- Depth 4:
  - Push 4 packets -> ri=0.
  - Same-cycle push and buf_clear_3 -> count held; FIFO order preserved across pointer wrap.
  - Async rst mid-stream -> FIFO empty and ri=1 immediately.

Source files
------------

// File: rtl/noc_input_port_if.sv
// Link bundle of one mesh router input port: upstream send/ready/data plus
// the five request/data buses toward the output arbiters and their pop strobes.
interface noc_input_port_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  si;
  logic                  ri;
  logic [DATA_WIDTH-1:0] datai;
  logic                  buf_clear_1;
  logic                  buf_clear_2;
  logic                  buf_clear_3;
  logic                  buf_clear_4;
  logic [4:0]            reqL;
  logic [4:0]            reqR;
  logic [4:0]            reqU;
  logic [4:0]            reqD;
  logic [4:0]            reqPE;
  logic [DATA_WIDTH-1:0] dataoL;
  logic [DATA_WIDTH-1:0] dataoR;
  logic [DATA_WIDTH-1:0] dataoU;
  logic [DATA_WIDTH-1:0] dataoD;
  logic [DATA_WIDTH-1:0] dataoPE;

  modport master (
    output si, datai, buf_clear_1, buf_clear_2, buf_clear_3, buf_clear_4,
    input  ri, reqL, reqR, reqU, reqD, reqPE,
    input  dataoL, dataoR, dataoU, dataoD, dataoPE
  );

  modport slave (
    input  si, datai, buf_clear_1, buf_clear_2, buf_clear_3, buf_clear_4,
    output ri, reqL, reqR, reqU, reqD, reqPE,
    output dataoL, dataoR, dataoU, dataoD, dataoPE
  );
endinterface

// File: rtl/noc_input_port.sv
// Mesh NoC router input port: a small FIFO buffers upstream packets and the
// head entry is XY-routed to exactly one of the five output arbiters.
module noc_input_port #(
  parameter int          DATA_WIDTH      = 64,
  parameter logic [15:0] CURRENT_ADDRESS = 16'h0000,
  parameter logic [4:0]  DIRECTION       = 5'b00001,
  parameter int          BUFFER_DEPTH    = 1
) (
  input logic              clk,
  input logic              rst,
  noc_input_port_if.slave  link
);
  localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUFFER_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_DEPTH);

  typedef enum logic [2:0] {
    ROUTE_NONE,
    ROUTE_L,
    ROUTE_R,
    ROUTE_U,
    ROUTE_D,
    ROUTE_PE
  } route_t;

  logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  any_clear;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;
  logic [7:0]            dest_x;
  logic [7:0]            dest_y;
  route_t                route;

  assign any_clear = link.buf_clear_1 | link.buf_clear_2 |
                     link.buf_clear_3 | link.buf_clear_4;
  assign link.ri   = (count != FULL_CNT);
  assign push      = link.si & link.ri;
  assign pop       = (count != '0) & any_clear;
  assign head      = mem[rd_ptr];
  assign dest_x    = head[47:40];
  assign dest_y    = head[39:32];

  // Storage carries no reset: entries are only observed while count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= link.datai;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Dimension-ordered routing: resolve X fully before considering Y.
  always_comb begin
    route = ROUTE_NONE;
    if (count != '0) begin
      if (dest_x > CURRENT_ADDRESS[15:8]) begin
        route = ROUTE_R;
      end else if (dest_x < CURRENT_ADDRESS[15:8]) begin
        route = ROUTE_L;
      end else if (dest_y > CURRENT_ADDRESS[7:0]) begin
        route = ROUTE_U;
      end else if (dest_y < CURRENT_ADDRESS[7:0]) begin
        route = ROUTE_D;
      end else begin
        route = ROUTE_PE;
      end
    end
  end

  always_comb begin
    link.reqL    = '0;
    link.reqR    = '0;
    link.reqU    = '0;
    link.reqD    = '0;
    link.reqPE   = '0;
    link.dataoL  = '0;
    link.dataoR  = '0;
    link.dataoU  = '0;
    link.dataoD  = '0;
    link.dataoPE = '0;
    case (route)
      ROUTE_L: begin
        link.reqL   = DIRECTION;
        link.dataoL = head;
      end
      ROUTE_R: begin
        link.reqR   = DIRECTION;
        link.dataoR = head;
      end
      ROUTE_U: begin
        link.reqU   = DIRECTION;
        link.dataoU = head;
      end
      ROUTE_D: begin
        link.reqD   = DIRECTION;
        link.dataoD = head;
      end
      ROUTE_PE: begin
        link.reqPE   = DIRECTION;
        link.dataoPE = head;
      end
      default: begin
      end
    endcase
  end
endmodule

// File: tb/tb_noc_input_port.sv
// Bench for noc_input_port: a depth-1 local-address instance and a depth-4
// instance at 0x0101, both compared against a queue-based reference model.
module tb_noc_input_port;
  localparam logic [15:0] ADDR_A  = 16'h0000;
  localparam logic [4:0]  DIR_A   = 5'b00001;
  localparam int          DEPTH_A = 1;
  localparam logic [15:0] ADDR_B  = 16'h0101;
  localparam logic [4:0]  DIR_B   = 5'b00100;
  localparam int          DEPTH_B = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;
  logic [63:0] qa[$];
  logic [63:0] qb[$];

  noc_input_port_if #(.DATA_WIDTH(64)) ifa ();
  noc_input_port_if #(.DATA_WIDTH(64)) ifb ();

  noc_input_port #(
    .DATA_WIDTH(64), .CURRENT_ADDRESS(ADDR_A), .DIRECTION(DIR_A), .BUFFER_DEPTH(DEPTH_A)
  ) dut_a (
    .clk(clk), .rst(rst), .link(ifa)
  );

  noc_input_port #(
    .DATA_WIDTH(64), .CURRENT_ADDRESS(ADDR_B), .DIRECTION(DIR_B), .BUFFER_DEPTH(DEPTH_B)
  ) dut_b (
    .clk(clk), .rst(rst), .link(ifb)
  );

  always #5 clk = ~clk;

  // Route index 0..4 = L, R, U, D, PE, decided by comparing coordinates as numbers.
  function automatic int routeOf(input logic [15:0] cur, input logic [63:0] pkt);
    int dx, dy, cx, cy;
    dx = int'(pkt[47:40]);
    dy = int'(pkt[39:32]);
    cx = int'(cur[15:8]);
    cy = int'(cur[7:0]);
    if (dx > cx) return 1;
    if (dx < cx) return 0;
    if (dy > cy) return 2;
    if (dy < cy) return 3;
    return 4;
  endfunction

  function automatic logic [63:0] randPkt();
    logic [63:0] p;
    p = {$urandom, $urandom};
    if ($urandom_range(0, 7) != 0) begin
      p[47:40] = 8'($urandom_range(0, 2));
      p[39:32] = 8'($urandom_range(0, 2));
    end
    return p;
  endfunction

  task automatic driveIdle();
    ifa.si = 1'b0;
    ifa.datai = '0;
    {ifa.buf_clear_4, ifa.buf_clear_3, ifa.buf_clear_2, ifa.buf_clear_1} = 4'b0;
    ifb.si = 1'b0;
    ifb.datai = '0;
    {ifb.buf_clear_4, ifb.buf_clear_3, ifb.buf_clear_2, ifb.buf_clear_1} = 4'b0;
  endtask

  // Called at a falling edge; drives one instance across one rising edge.
  task automatic applyStimulus(input int which, input logic si, input logic [63:0] data,
                               input logic [3:0] clr);
    int  size;
    int  depth;
    bit  do_push;
    bit  do_pop;
    driveIdle();
    if (which == 0) begin
      ifa.si = si;
      ifa.datai = data;
      {ifa.buf_clear_4, ifa.buf_clear_3, ifa.buf_clear_2, ifa.buf_clear_1} = clr;
      size = qa.size();
      depth = DEPTH_A;
    end else begin
      ifb.si = si;
      ifb.datai = data;
      {ifb.buf_clear_4, ifb.buf_clear_3, ifb.buf_clear_2, ifb.buf_clear_1} = clr;
      size = qb.size();
      depth = DEPTH_B;
    end
    do_push = si && (size < depth);
    do_pop  = (size > 0) && (clr != 4'b0);
    @(posedge clk);
    if (which == 0) begin
      if (do_pop) void'(qa.pop_front());
      if (do_push) qa.push_back(data);
    end else begin
      if (do_pop) void'(qb.pop_front());
      if (do_push) qb.push_back(data);
    end
    @(negedge clk);
    driveIdle();
  endtask

  task automatic checkOutput(input int which, input string tag);
    logic        act_ri;
    logic [4:0]  act_req[5];
    logic [63:0] act_dat[5];
    logic [4:0]  dir;
    logic [15:0] cur;
    logic [63:0] head;
    int          depth;
    int          size;
    int          route;
    logic        exp_ri;
    logic [4:0]  exp_req;
    logic [63:0] exp_dat;
    head = '0;
    if (which == 0) begin
      act_ri  = ifa.ri;
      act_req = '{ifa.reqL, ifa.reqR, ifa.reqU, ifa.reqD, ifa.reqPE};
      act_dat = '{ifa.dataoL, ifa.dataoR, ifa.dataoU, ifa.dataoD, ifa.dataoPE};
      dir = DIR_A;
      cur = ADDR_A;
      depth = DEPTH_A;
      size = qa.size();
      if (size > 0) head = qa[0];
    end else begin
      act_ri  = ifb.ri;
      act_req = '{ifb.reqL, ifb.reqR, ifb.reqU, ifb.reqD, ifb.reqPE};
      act_dat = '{ifb.dataoL, ifb.dataoR, ifb.dataoU, ifb.dataoD, ifb.dataoPE};
      dir = DIR_B;
      cur = ADDR_B;
      depth = DEPTH_B;
      size = qb.size();
      if (size > 0) head = qb[0];
    end
    route  = (size > 0) ? routeOf(cur, head) : -1;
    exp_ri = (size != depth);
    tests_run++;
    assert (act_ri === exp_ri) else begin
      tests_failed++;
      $error("FAIL %s ri observed=%b expected=%b", tag, act_ri, exp_ri);
    end
    for (int i = 0; i < 5; i++) begin
      exp_req = (i == route) ? dir : 5'b0;
      exp_dat = (i == route) ? head : 64'b0;
      tests_run++;
      assert (act_req[i] === exp_req) else begin
        tests_failed++;
        $error("FAIL %s req[%0d] observed=%b expected=%b", tag, i, act_req[i], exp_req);
      end
      tests_run++;
      assert (act_dat[i] === exp_dat) else begin
        tests_failed++;
        $error("FAIL %s datao[%0d] observed=%h expected=%h", tag, i, act_dat[i], exp_dat);
      end
    end
  endtask

  initial begin
    logic [15:0] route_dest[5];
    logic [63:0] pkt;
    route_dest = '{16'h0201, 16'h0001, 16'h0102, 16'h0100, 16'h0101};

    driveIdle();
    rst = 1'b0;
    #2;
    checkOutput(0, "reset_a");
    checkOutput(1, "reset_b");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput(0, "release_a");
    checkOutput(1, "release_b");

    applyStimulus(0, 1'b1, 64'hD000_0000_1111_1111, 4'b0000);
    checkOutput(0, "local_push");
    applyStimulus(0, 1'b1, 64'hD000_0000_2222_2222, 4'b0000);
    checkOutput(0, "full_drop");
    applyStimulus(0, 1'b0, 64'h0, 4'b0001);
    checkOutput(0, "clear");
    applyStimulus(0, 1'b0, 64'h0, 4'b0001);
    checkOutput(0, "clear_empty");
    applyStimulus(0, 1'b1, 64'h4000_0000_3333_3333, 4'b0000);
    applyStimulus(0, 1'b1, 64'h4000_0000_4444_4444, 4'b1011);
    checkOutput(0, "full_push_pop");
    applyStimulus(0, 1'b1, 64'h4000_0000_5555_5555, 4'b0000);
    checkOutput(0, "refill");
    applyStimulus(0, 1'b0, 64'h0, 4'b1111);
    checkOutput(0, "multi_clear");

    for (int i = 0; i < 5; i++) begin
      pkt = 64'h2000_0000_0000_0000 | (64'(route_dest[i]) << 32) | 64'(i);
      applyStimulus(1, 1'b1, pkt, 4'b0000);
      checkOutput(1, $sformatf("route_%0d", i));
      applyStimulus(1, 1'b0, 64'h0, 4'b0010);
      checkOutput(1, $sformatf("route_clear_%0d", i));
    end

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1'b1, randPkt(), 4'b0000);
      checkOutput(1, $sformatf("fill_%0d", i));
    end
    applyStimulus(1, 1'b1, randPkt(), 4'b0000);
    checkOutput(1, "fill_drop");
    applyStimulus(1, 1'b0, 64'h0, 4'b0100);
    checkOutput(1, "fill_pop");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 1'b1, randPkt(), 4'b0100);
      checkOutput(1, $sformatf("push_pop_%0d", i));
    end

    for (int i = 0; i < 300; i++) begin
      applyStimulus(1, 1'($urandom_range(0, 1)), randPkt(),
                    ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000);
      checkOutput(1, $sformatf("rand_b_%0d", i));
    end
    for (int i = 0; i < 100; i++) begin
      applyStimulus(0, 1'($urandom_range(0, 1)), randPkt(),
                    ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'b0000);
      checkOutput(0, $sformatf("rand_a_%0d", i));
    end

    applyStimulus(1, 1'b1, randPkt(), 4'b0000);
    applyStimulus(1, 1'b1, randPkt(), 4'b0000);
    applyStimulus(0, 1'b1, randPkt(), 4'b0000);
    checkOutput(1, "pre_reset_b");
    #2;
    rst = 1'b0;
    qa.delete();
    qb.delete();
    #1;
    checkOutput(1, "async_reset_b");
    checkOutput(0, "async_reset_a");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput(1, "post_reset_b");
    applyStimulus(1, 1'b1, 64'h1000_0102_ABCD_0001, 4'b0000);
    checkOutput(1, "post_reset_push");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
